// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - Multiply/divide unit E-stage bus.
//
// Groups the pipeline-facing signals of the MDU:
//   Start  - one-cycle issue pulse from the E stage
//   MDUOp  - 4-bit operation code
//   A, B   - forwarded rs / rt operands
//   Busy   - multi-cycle operation in flight
//   Out    - MFHI/MFLO read data (combinational)
//   HI, LO - architectural HI/LO registers
// master: pipeline side (drives Start/MDUOp/A/B); slave: the MDU.

interface mdu_if;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] Out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDUOp, A, B, input Busy, Out, HI, LO);
  modport slave  (input Start, MDUOp, A, B, output Busy, Out, HI, LO);
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - Multi-cycle multiply/divide unit with HI/LO registers.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - mdu_if.slave (Start, MDUOp, A, B in; Busy, Out, HI, LO out)
//
// The result is computed combinationally on the Start cycle and parked in
// shadow registers; a down-counter then models the unit latency (5 cycles
// for multiply-class ops, 10 for divides) before HI/LO are committed.
//
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (opcodes 9..12). Without it those opcodes behave as NONE.

module mdu (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  count;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] shadow_hi;
  logic [31:0] shadow_lo;

  // Products: the low 64 bits of a product of sign-extended operands equal
  // the signed 32x32 product, so one 64-bit multiplier shape serves both.
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Division on magnitudes, then sign fix-up. This truncates toward zero,
  // gives the remainder the sign of A, and makes 0x80000000 / -1 come out
  // as quotient 0x80000000, remainder 0 without special casing.
  logic        div_signed;
  logic        b_zero;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign div_signed = (bus.MDUOp == OP_DIV);
  assign b_zero     = (bus.B == 32'd0);
  assign dividend   = (div_signed && bus.A[31]) ? -bus.A : bus.A;
  assign divisor    = (div_signed && bus.B[31]) ? -bus.B : bus.B;
  assign q_mag      = b_zero ? 32'd0 : dividend / divisor;
  assign r_mag      = b_zero ? 32'd0 : dividend % divisor;
  assign quot       = (div_signed && (bus.A[31] ^ bus.B[31])) ? -q_mag : q_mag;
  assign rem        = (div_signed && bus.A[31]) ? -r_mag : r_mag;

  // Op decode and the value {HI,LO} will take at commit. Divide by zero
  // keeps the current HI/LO so the commit is a no-op.
  logic        is_mul;
  logic        is_div;
  logic [63:0] result;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    result = {hi_q, lo_q};
    case (bus.MDUOp)
      OP_MULT: begin
        is_mul = 1'b1;
        result = prod_s;
      end
      OP_MULTU: begin
        is_mul = 1'b1;
        result = prod_u;
      end
      OP_DIV, OP_DIVU: begin
        is_div = 1'b1;
        if (!b_zero) result = {rem, quot};
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        is_mul = 1'b1;
        result = {hi_q, lo_q} + prod_s;
      end
      OP_MADDU: begin
        is_mul = 1'b1;
        result = {hi_q, lo_q} + prod_u;
      end
      OP_MSUB: begin
        is_mul = 1'b1;
        result = {hi_q, lo_q} - prod_s;
      end
      OP_MSUBU: begin
        is_mul = 1'b1;
        result = {hi_q, lo_q} - prod_u;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 4'd0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      shadow_hi <= 32'd0;
      shadow_lo <= 32'd0;
    end else if (state == IDLE) begin
      if (bus.Start && (is_mul || is_div)) begin
        {shadow_hi, shadow_lo} <= result;
        count  <= is_div ? DIV_CYCLES : MUL_CYCLES;
        busy_q <= 1'b1;
        state  <= RUN;
      end else if (!bus.Start && bus.MDUOp == OP_MTHI) begin
        hi_q <= bus.A;
      end else if (!bus.Start && bus.MDUOp == OP_MTLO) begin
        lo_q <= bus.A;
      end
    end else begin
      // RUN: Start, MTHI/MTLO and operand changes are all ignored here.
      if (count == 4'd1) begin
        hi_q   <= shadow_hi;
        lo_q   <= shadow_lo;
        count  <= 4'd0;
        busy_q <= 1'b0;
        state  <= IDLE;
      end else begin
        count <= count - 4'd1;
      end
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.Out  = (bus.MDUOp == OP_MFHI) ? hi_q :
                    (bus.MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - Self-checking bench for mdu against a cycle-accurate reference model.

module tb_mdu;
  logic clk;
  logic reset;
  mdu_if bus ();

  mdu dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: architectural HI/LO plus one pending result that
  // becomes visible in cycle `done`.
  longint      cyc = 0;
  bit          pending = 1'b0;
  longint      done = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_edge(logic st, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    bit was_busy;
    bit take;
    int lat;
    logic [63:0] r;
    longint sa, sb;
    longint unsigned ua, ub;
    int da, db;
    was_busy = pending;
    if (pending && cyc + 1 == done) begin
      m_hi = p_hi;
      m_lo = p_lo;
      pending = 1'b0;
    end
    if (!was_busy) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = a;
      ub = b;
      da = $signed(a);
      db = $signed(b);
      if (st) begin
        take = 1'b1;
        lat = 5;
        r = {m_hi, m_lo};
        case (op)
          4'd1: r = sa * sb;
          4'd2: r = ua * ub;
          4'd3, 4'd4: begin
            lat = 10;
            if (b == 0) r = {m_hi, m_lo};
            else if (op == 4'd4) r = {a % b, a / b};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
            else r = {32'(da % db), 32'(da / db)};
          end
          4'd9:  if (MADD_EN) r = {m_hi, m_lo} + 64'(sa * sb); else take = 1'b0;
          4'd10: if (MADD_EN) r = {m_hi, m_lo} + 64'(ua * ub); else take = 1'b0;
          4'd11: if (MADD_EN) r = {m_hi, m_lo} - 64'(sa * sb); else take = 1'b0;
          4'd12: if (MADD_EN) r = {m_hi, m_lo} - 64'(ua * ub); else take = 1'b0;
          default: take = 1'b0;
        endcase
        if (take) begin
          {p_hi, p_lo} = r;
          pending = 1'b1;
          done = cyc + 1 + lat;
        end
      end else if (op == 4'd7) begin
        m_hi = a;
      end else if (op == 4'd8) begin
        m_lo = a;
      end
    end
  endfunction

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [31:0] exp_out;
    exp_out = (bus.MDUOp == 4'd5) ? m_hi : (bus.MDUOp == 4'd6) ? m_lo : 32'd0;
    chk("busy", {31'd0, bus.Busy}, {31'd0, pending});
    chk("hi", bus.HI, m_hi);
    chk("lo", bus.LO, m_lo);
    chk("out", bus.Out, exp_out);
  end

  // Called at posedge+1; drives inputs for the coming edge.
  task automatic step(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = st;
    bus.MDUOp = op;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    model_edge(st, op, a, b);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    bus.Start = 1'b0;
    bus.MDUOp = 4'd0;
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    pending = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // Counts busy cycles after a Start step; an optional second Start with
  // different operands is pulsed in busy cycle 2.
  task automatic count_busy(output int n, input bit second_start);
    n = 0;
    while (bus.Busy && n < 30) begin
      if (second_start && n == 1) step(1'b1, 4'd4, $urandom, $urandom | 1);
      else step(1'b0, 4'd0, $urandom, $urandom);
      n++;
    end
  endtask

  task automatic op_test(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    step(1'b1, op, a, b);
    count_busy(n, 1'b0);
    chk({name, "_busy_len"}, n, exp_n);
    chk({name, "_hi"}, bus.HI, exp_hi);
    chk({name, "_lo"}, bus.LO, exp_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [3:0] op;
    logic [31:0] a, b;
    reset = 1'b1;
    bus.Start = 1'b0;
    bus.MDUOp = 4'd0;
    bus.A = '0;
    bus.B = '0;
    @(posedge clk);
    #1;
    do_reset();

    op_test("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    op_test("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
    op_test("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op_test("divu0", 4'd4, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op_test("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    op_test("divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    // MTHI then MFHI.
    step(1'b0, 4'd7, 32'h12345678, 32'd0);
    step(1'b0, 4'd5, 32'd0, 32'd0);
    chk("mfhi_out", bus.Out, 32'h12345678);

    // Start with a non-mult/div op is ignored.
    step(1'b1, 4'd7, 32'hAAAA5555, 32'd0);
    chk("start_mthi_busy", {31'd0, bus.Busy}, 32'd0);
    chk("start_mthi_hi", bus.HI, 32'h12345678);

    // Second Start plus operand changes during RUN.
    step(1'b1, 4'd1, 32'h10, 32'h20);
    count_busy(n, 1'b1);
    chk("restart_busy_len", n, 5);
    chk("restart_hi", bus.HI, 32'd0);
    chk("restart_lo", bus.LO, 32'h200);

    // Reset during a divide at busy cycle 4.
    step(1'b1, 4'd3, 32'd100, 32'd7);
    repeat (3) step(1'b0, 4'd0, 32'd0, 32'd0);
    do_reset();
    repeat (15) step(1'b0, 4'd0, 32'd0, 32'd0);
    chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
    chk("abort_hi", bus.HI, 32'd0);
    chk("abort_lo", bus.LO, 32'd0);

    // MTLO during RUN is ignored; first Start after reset behaves normally.
    step(1'b1, 4'd1, 32'd3, 32'd4);
    step(1'b0, 4'd8, 32'hDEADBEEF, 32'd0);
    chk("mtlo_run_lo", bus.LO, 32'd0);
    count_busy(n, 1'b0);
    chk("mtlo_run_busy_len", n, 4);
    chk("mtlo_run_final_lo", bus.LO, 32'd12);

    // Multiply-accumulate opcode.
    step(1'b0, 4'd7, 32'd0, 32'd0);
    step(1'b0, 4'd8, 32'hFFFFFFFF, 32'd0);
    if (MADD_EN) op_test("maddu", 4'd10, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    else op_test("maddu", 4'd10, 32'd1, 32'd1, 0, 32'd0, 32'hFFFFFFFF);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(0, 40) - 20; b = $urandom_range(0, 10) - 5; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      op = 4'($urandom_range(0, 15));
      if (!bus.Busy && $urandom_range(0, 2) == 0) step(1'b1, op, a, b);
      else step($urandom_range(0, 9) == 0, op, a, b);
    end

    repeat (12) step(1'b0, 4'd0, 32'd0, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The interface SHALL have one clock and an asynchronous, active-high reset, named as listed below.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  one-cycle pulse from E stage; E-stage instruction is a multiply/divide-class op.
REQ-005 MDUOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; other codes behave as NONE.
REQ-006 A  input  32  forwarded rs operand.
REQ-007 B  input  32  forwarded rt operand.
REQ-008 Busy  output  1  high while a multi-cycle op is in flight; consumed by hazard control together with Start.
REQ-009 Out  output  32  MFHI -> HI, MFLO -> LO, otherwise 0; combinational.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.

Function
REQ-012 Two states SHALL exist: IDLE and RUN. A 4-bit down-counter SHALL hold the remaining busy cycles.
REQ-013 IDLE with Start=1 and a MULT/MULTU/MADD-class op SHALL load counter=5, latch the computed result into shadow registers, and go to RUN.
REQ-014 IDLE with Start=1 and DIV/DIVU SHALL load counter=10, latch the result into shadow registers, and go to RUN.
REQ-015 RUN SHALL decrement the counter each cycle. Busy SHALL be high throughout RUN.
REQ-016 On the edge where the counter reaches 0, the shadow registers SHALL be written to HI/LO, the state SHALL return to IDLE, and Busy SHALL fall in the same cycle.
REQ-017 Timing: Start in cycle T -> Busy high in cycles T+1..T+5 (mult) or T+1..T+10 (div). The new HI/LO SHALL be visible in cycle T+6 or T+11 respectively.
REQ-018 MULT/MULTU SHALL form the 64-bit signed/unsigned product {HI,LO} = A*B.
REQ-019 DIV/DIVU SHALL produce LO=quotient and HI=remainder, signed/unsigned; signed division SHALL truncate toward zero, with the remainder taking the sign of A.
REQ-020 For 0x80000000 / 0xFFFFFFFF (signed), the result SHALL be LO=0x80000000, HI=0.
REQ-021 Divide by zero (B=0) SHALL still run 10 busy cycles and SHALL leave HI/LO unchanged at completion.
REQ-022 MTHI/MTLO SHALL write A into HI/LO at the next edge, only in IDLE with Start=0; they SHALL be ignored in RUN.
REQ-023 Start asserted while in RUN SHALL be ignored (hazard control guarantees this cannot occur; the block does not rely on it).
REQ-024 Start with a non-mult/div op SHALL be ignored.
REQ-025 MFHI/MFLO during RUN SHALL return the pre-op HI/LO (stall prevents use; no bypass of the shadow registers).
REQ-026 Operands SHALL be sampled only on the Start cycle; changes to A/B during RUN SHALL have no effect.

Reset
REQ-027 reset=1 SHALL asynchronously force HI=0, LO=0, Busy=0, counter=0, state=IDLE, and shadow registers=0.
REQ-028 Reset during RUN SHALL abort the operation; no HI/LO commit SHALL occur after reset deasserts.
REQ-029 The first Start accepted after reset deassertion SHALL behave as REQ-013/REQ-014.

Configuration
REQ-030 Macro MDU_MADD_EN: when defined, MADD/MADDU/MSUB/MSUBU SHALL compute {HI,LO} ± A*B (64-bit, signed/unsigned, wrapping) with the 5-cycle latency, using the HI/LO values present at Start.
REQ-031 When MDU_MADD_EN is undefined, opcodes 9..12 SHALL behave as NONE: no Busy, no HI/LO change.

Verification
REQ-032 MULT A=0xFFFFFFFE, B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-033 DIV A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> Busy high 10 cycles, HI/LO unchanged.
REQ-034 MTHI A=0x12345678, then MFHI -> Out=0x12345678 the next cycle; MTLO issued during RUN -> LO unchanged.
REQ-035 DIV started, reset pulsed at busy cycle 4 -> Busy=0, HI=LO=0 immediately; no later commit.
REQ-036 With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles; without the macro -> Busy stays 0 and HI/LO are unchanged.
REQ-037 A second Start pulsed in busy cycle 2, with A/B changed during RUN -> the result reflects only the first operands, and the Busy length is unchanged.
